sram_arbiter: RTL and testbench
===============================

Name: sram_arbiter

Overview:
- Two-port arbiter and sequencer for the 16-bit, 20-bit-address external SRAM. It feeds the Mem2IO-style datapath with CE/UB/LB/OE/WE strobes, an address and write data.
- Port 0 is the video/sprite fetch requester and port 1 is the game-logic requester.
- It serialises single-word accesses, shares the SRAM between the two ports round-robin, and returns read data with a one-cycle ack pulse.

Parameters:
- ACCESS_CYCLES, 2: number of cycles the strobes are held active per access; legal range 1..15.
- ADDR_W, 20: SRAM address width.
- DATA_W, 16: SRAM data width; byte lanes are fixed at 2.

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- req0, req1  in  1 each  access request, held until the matching ack
- we0, we1  in  1 each  1 = write, 0 = read
- addr0, addr1  in  ADDR_W each  word address
- wdata0, wdata1  in  DATA_W each  write data
- be0, be1  in  2 each  byte enables; [1] = upper byte, [0] = lower byte
- ack0, ack1  out  1 each  one-cycle completion pulse
- rdata  out  DATA_W  read data, valid during ack and held until the next read completes
- ADDR  out  ADDR_W  SRAM address
- CE, UB, LB, OE, WE  out  1 each  SRAM strobes, active low
- Data_to_SRAM  out  DATA_W  write data toward the pad driver
- sram_drive  out  1  tristate enable for Data_to_SRAM
- Data_from_SRAM  in  DATA_W  SRAM read bus

Behaviour:
- Reset values:
  - state IDLE; CE=UB=LB=OE=WE=1.
  - ADDR=0, Data_to_SRAM=0, sram_drive=0, rdata=0, ack0=ack1=0.
  - last_grant=1, so port 0 wins the first tie.
- FSM states: IDLE -> ACCESS -> DONE -> IDLE.
- IDLE: requests are sampled here only.
  - If exactly one req is high, grant it.
  - If both are high, grant the port other than last_grant.
  - On grant, register ADDR, we, be and wdata from the granted port, update last_grant, load cnt=ACCESS_CYCLES-1, and go to ACCESS.
  - With no req, stay in IDLE with all strobes high.
- ACCESS:
  - CE=0, UB=~be[1], LB=~be[0].
  - Read: OE=0, WE=1. Write: OE=1, WE=0, sram_drive=1.
  - Decrement cnt each cycle; when cnt==0, go to DONE.
  - Read: capture Data_from_SRAM into rdata on the cycle cnt==0. Byte lanes with be=0 are forced to 0.
- DONE:
  - All strobes return to 1. ADDR, Data_to_SRAM and sram_drive are held for one cycle of hold time.
  - The granted port's ack=1 for exactly this cycle; go to IDLE.
- Latency: req high in IDLE at cycle N -> strobes active N+1..N+ACCESS_CYCLES -> ack at N+ACCESS_CYCLES+1. Default: ack 3 cycles after the grant cycle.
- Throughput: one access per ACCESS_CYCLES+2 cycles.
- Requester rules:
  - Hold req, we, addr, wdata and be stable until ack.
  - req may still be high during the ack cycle; it must be low in the following cycle unless a new access is intended.
  - A req still high in the IDLE cycle after ack is treated as a new request.
- Fairness: with both ports requesting continuously, grants strictly alternate 0,1,0,1.
- be=2'b00: the access is still sequenced with UB=LB=1. ack is given; a read returns rdata=0.
- Only the granted port's req is observed in ACCESS and DONE; the other port's req changing there has no effect.
- Reset mid-access: the next edge forces the reset values. No ack is issued for the aborted access; the requester must re-request.
- ack0 and ack1 are never high simultaneously.

Decomposition:
- Package sram_arb_pkg:
  - state_t enum {IDLE, ACCESS, DONE}.
  - port_t (1-bit port index).
  - localparams SRAM_ADDR_W=20, SRAM_DATA_W=16.
- Sub-module rr_arbiter2: combinational 2-way round-robin grant.
  - Inputs: req[1:0], last_grant. Outputs: grant_valid, grant_idx.
- The FSM, counter and registers stay in sram_arbiter.

Test Plan:
- Reset held 3 cycles with req0=1 -> all strobes 1, sram_drive=0, no ack. After release, first grant goes to port 0.
- Port 1 write: addr1=20'h00123, wdata1=16'hBEEF, be1=2'b11, ACCESS_CYCLES=2.
  - Required: WE=0, CE=0, OE=1, sram_drive=1 for exactly 2 cycles.
  - Then strobes go to 1 with ADDR and data held 1 cycle, and ack1 pulses.
- Port 0 read of 20'h00123, model returns 16'hBEEF, be0=2'b01.
  - Required: OE=0, WE=1, UB=1, LB=0 during ACCESS; rdata=16'h00EF at ack0.
- Both req0 and req1 held for 4 accesses -> grant order 0,1,0,1; each ack 3 cycles after its grant cycle; never both acks high.
- Reset asserted in the second ACCESS cycle of a write -> strobes go to 1 the next cycle, no ack1. A re-issued request completes normally.
- be0=2'b00 read -> UB=LB=1 throughout, ack0 given, rdata=16'h0000.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// ----------------------------------------------------------------
// sram_arb_pkg : shared types and widths for the SRAM arbiter
// Rev 1.0
// ----------------------------------------------------------------
`default_nettype none

package sram_arb_pkg;

  localparam int SRAM_ADDR_W = 20;
  localparam int SRAM_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  typedef logic port_t;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter2.sv
// ----------------------------------------------------------------
// rr_arbiter2 : combinational two-way round-robin grant
// Rev 1.0
// ----------------------------------------------------------------
`default_nettype none

module rr_arbiter2
  import sram_arb_pkg::*;
(
  input  logic [1:0] i_req,
  input  port_t      i_last_grant,
  output logic       o_grant_valid,
  output port_t      o_grant_idx
);

  always_comb begin
    o_grant_valid = |i_req;
    // On a tie the port that did not win last time goes next.
    if (&i_req) begin
      o_grant_idx = ~i_last_grant;
    end else begin
      o_grant_idx = i_req[1];
    end
  end

endmodule

`default_nettype wire

// File: rtl/sram_arbiter.sv
// ----------------------------------------------------------------
// sram_arbiter : two-port round-robin sequencer for the external SRAM
// Rev 1.0
// ----------------------------------------------------------------
`default_nettype none

module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ACCESS_CYCLES = 2,
  parameter int ADDR_W        = SRAM_ADDR_W,
  parameter int DATA_W        = SRAM_DATA_W
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  input  logic [1:0]        be0,
  input  logic [1:0]        be1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] ADDR,
  output logic              CE,
  output logic              UB,
  output logic              LB,
  output logic              OE,
  output logic              WE,
  output logic [DATA_W-1:0] Data_to_SRAM,
  output logic              sram_drive,
  input  logic [DATA_W-1:0] Data_from_SRAM
);

  localparam logic [3:0] c_cnt_load = 4'(ACCESS_CYCLES - 1);
  localparam int         c_lane_w   = DATA_W / 2;

  state_t              r_state;
  logic [3:0]          r_cnt;
  port_t               r_last_grant;
  port_t               r_port;
  logic                r_we;
  logic [1:0]          r_be;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_ce, r_ub, r_lb, r_oe, r_we_n, r_drive;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_ack0, r_ack1;

  logic                w_grant_valid;
  port_t               w_grant_idx;
  logic                w_sel_we;
  logic [1:0]          w_sel_be;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [DATA_W-1:0]   w_sel_wdata;
  logic [DATA_W-1:0]   w_lane_mask;

  rr_arbiter2 u_rr (
    .i_req         ({req1, req0}),
    .i_last_grant  (r_last_grant),
    .o_grant_valid (w_grant_valid),
    .o_grant_idx   (w_grant_idx)
  );

  assign w_sel_we    = w_grant_idx ? we1    : we0;
  assign w_sel_be    = w_grant_idx ? be1    : be0;
  assign w_sel_addr  = w_grant_idx ? addr1  : addr0;
  assign w_sel_wdata = w_grant_idx ? wdata1 : wdata0;
  assign w_lane_mask = {{c_lane_w{r_be[1]}}, {c_lane_w{r_be[0]}}};

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state      <= IDLE;
      r_cnt        <= 4'd0;
      r_last_grant <= 1'b1;
      r_port       <= 1'b0;
      r_we         <= 1'b0;
      r_be         <= 2'b00;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_ce         <= 1'b1;
      r_ub         <= 1'b1;
      r_lb         <= 1'b1;
      r_oe         <= 1'b1;
      r_we_n       <= 1'b1;
      r_drive      <= 1'b0;
      r_rdata      <= '0;
      r_ack0       <= 1'b0;
      r_ack1       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant_valid) begin
            r_port       <= w_grant_idx;
            r_last_grant <= w_grant_idx;
            r_we         <= w_sel_we;
            r_be         <= w_sel_be;
            r_addr       <= w_sel_addr;
            r_wdata      <= w_sel_wdata;
            r_cnt        <= c_cnt_load;
            r_ce         <= 1'b0;
            r_ub         <= ~w_sel_be[1];
            r_lb         <= ~w_sel_be[0];
            r_oe         <= w_sel_we;
            r_we_n       <= ~w_sel_we;
            r_drive      <= w_sel_we;
            r_state      <= ACCESS;
          end
        end
        ACCESS: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            // Strobes release; address, data and drive persist through DONE for hold time.
            r_ce   <= 1'b1;
            r_ub   <= 1'b1;
            r_lb   <= 1'b1;
            r_oe   <= 1'b1;
            r_we_n <= 1'b1;
            if (!r_we) begin
              r_rdata <= Data_from_SRAM & w_lane_mask;
            end
            r_ack0  <= (r_port == 1'b0);
            r_ack1  <= (r_port == 1'b1);
            r_state <= DONE;
          end
        end
        DONE: begin
          r_ack0  <= 1'b0;
          r_ack1  <= 1'b0;
          r_drive <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ack0         = r_ack0;
  assign ack1         = r_ack1;
  assign rdata        = r_rdata;
  assign ADDR         = r_addr;
  assign CE           = r_ce;
  assign UB           = r_ub;
  assign LB           = r_lb;
  assign OE           = r_oe;
  assign WE           = r_we_n;
  assign Data_to_SRAM = r_wdata;
  assign sram_drive   = r_drive;

endmodule

`default_nettype wire

// File: tb/tb_sram_arbiter.sv
// ----------------------------------------------------------------
// tb_sram_arbiter : directed self-checking bench for sram_arbiter
// Rev 1.0
// ----------------------------------------------------------------
`default_nettype none

module tb_sram_arbiter;

  localparam int AC = 2;

  logic        Clk;
  logic        Reset;
  logic        req0, req1, we0, we1;
  logic [19:0] addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic [1:0]  be0, be1;
  logic        ack0, ack1;
  logic [15:0] rdata;
  logic [19:0] ADDR;
  logic        CE, UB, LB, OE, WE;
  logic [15:0] Data_to_SRAM;
  logic        sram_drive;
  logic [15:0] Data_from_SRAM;

  int n_checks = 0;
  int n_errors = 0;

  sram_arbiter #(.ACCESS_CYCLES(AC), .ADDR_W(20), .DATA_W(16)) dut (
    .Clk(Clk), .Reset(Reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .be0(be0), .be1(be1), .ack0(ack0), .ack1(ack1), .rdata(rdata),
    .ADDR(ADDR), .CE(CE), .UB(UB), .LB(LB), .OE(OE), .WE(WE),
    .Data_to_SRAM(Data_to_SRAM), .sram_drive(sram_drive),
    .Data_from_SRAM(Data_from_SRAM)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Small SRAM model: byte-lane writes while CE/WE low, reads visible only with CE/OE low.
  logic [15:0] mem [256];
  always @(posedge Clk) begin
    if (!CE && !WE) begin
      if (!UB) mem[ADDR[7:0]][15:8] <= Data_to_SRAM[15:8];
      if (!LB) mem[ADDR[7:0]][7:0]  <= Data_to_SRAM[7:0];
    end
  end
  assign Data_from_SRAM = (!CE && !OE) ? mem[ADDR[7:0]] : 16'hDEAD;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  always @(negedge Clk) begin
    chk("ack_excl", {31'b0, ack0 & ack1}, 32'd0);
  end

  // Starts in the IDLE cycle where the request is sampled; ends in the following IDLE cycle.
  task automatic run_one(input int port, input logic we, input logic [1:0] be,
                         input logic [19:0] addr, input logic [15:0] wdata,
                         input logic [15:0] exp_rd, input bit drop);
    logic [4:0] exp_strb;
    exp_strb = {1'b0, ~be[1], ~be[0], we, ~we};
    for (int c = 0; c < AC; c++) begin
      tick();
      chk("acc_strobes", {27'b0, CE, UB, LB, OE, WE}, {27'b0, exp_strb});
      chk("acc_addr", {12'b0, ADDR}, {12'b0, addr});
      chk("acc_drive", {31'b0, sram_drive}, {31'b0, we});
      chk("acc_ack", {30'b0, ack1, ack0}, 32'd0);
      if (we) chk("acc_wdata", {16'b0, Data_to_SRAM}, {16'b0, wdata});
    end
    tick();
    chk("done_strobes", {27'b0, CE, UB, LB, OE, WE}, 32'h1F);
    chk("done_addr", {12'b0, ADDR}, {12'b0, addr});
    chk("done_drive", {31'b0, sram_drive}, {31'b0, we});
    chk("done_ack", {30'b0, ack1, ack0}, (port == 1) ? 32'd2 : 32'd1);
    if (we) chk("done_wdata", {16'b0, Data_to_SRAM}, {16'b0, wdata});
    else    chk("done_rdata", {16'b0, rdata}, {16'b0, exp_rd});
    if (drop) begin
      if (port == 0) req0 = 1'b0;
      else           req1 = 1'b0;
    end
    tick();
    chk("idle_ack", {30'b0, ack1, ack0}, 32'd0);
    chk("idle_drive", {31'b0, sram_drive}, 32'd0);
    chk("idle_strobes", {27'b0, CE, UB, LB, OE, WE}, 32'h1F);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset  = 1'b1;
    req0   = 1'b1;  we0 = 1'b1; addr0 = 20'h00040; wdata0 = 16'hA5C3; be0 = 2'b11;
    req1   = 1'b0;  we1 = 1'b1; addr1 = 20'h00123; wdata1 = 16'hBEEF; be1 = 2'b11;

    // Reset held with a pending request
    repeat (3) begin
      tick();
      chk("rst_strobes", {27'b0, CE, UB, LB, OE, WE}, 32'h1F);
      chk("rst_drive", {31'b0, sram_drive}, 32'd0);
      chk("rst_ack", {30'b0, ack1, ack0}, 32'd0);
    end
    chk("rst_addr", {12'b0, ADDR}, 32'd0);
    chk("rst_rdata", {16'b0, rdata}, 32'd0);
    chk("rst_wdata", {16'b0, Data_to_SRAM}, 32'd0);

    // Tie after reset: port 0 first, then port 1 write of BEEF
    req1  = 1'b1;
    Reset = 1'b0;
    run_one(0, 1'b1, 2'b11, 20'h00040, 16'hA5C3, 16'h0000, 1'b1);
    run_one(1, 1'b1, 2'b11, 20'h00123, 16'hBEEF, 16'h0000, 1'b1);

    // Port 0 lower-byte read
    we0 = 1'b0; addr0 = 20'h00123; be0 = 2'b01; req0 = 1'b1;
    run_one(0, 1'b0, 2'b01, 20'h00123, 16'h0000, 16'h00EF, 1'b1);

    // Reset in the second ACCESS cycle of a port 1 write
    we1 = 1'b1; addr1 = 20'h00077; wdata1 = 16'h1111; be1 = 2'b11; req1 = 1'b1;
    tick();
    tick();
    chk("mid_ce", {31'b0, CE}, 32'd0);
    Reset = 1'b1;
    req1  = 1'b0;
    tick();
    chk("abort_strobes", {27'b0, CE, UB, LB, OE, WE}, 32'h1F);
    chk("abort_drive", {31'b0, sram_drive}, 32'd0);
    chk("abort_ack", {30'b0, ack1, ack0}, 32'd0);
    Reset = 1'b0;
    tick();
    chk("abort_ack2", {30'b0, ack1, ack0}, 32'd0);
    chk("abort_idle_ce", {31'b0, CE}, 32'd1);
    req1 = 1'b1;
    run_one(1, 1'b1, 2'b11, 20'h00077, 16'h1111, 16'h0000, 1'b1);

    // Both ports requesting continuously: grants alternate 0,1,0,1
    we0 = 1'b0; addr0 = 20'h00040; be0 = 2'b11;
    we1 = 1'b0; addr1 = 20'h00077; be1 = 2'b11;
    req0 = 1'b1; req1 = 1'b1;
    run_one(0, 1'b0, 2'b11, 20'h00040, 16'h0000, 16'hA5C3, 1'b0);
    run_one(1, 1'b0, 2'b11, 20'h00077, 16'h0000, 16'h1111, 1'b0);
    run_one(0, 1'b0, 2'b11, 20'h00040, 16'h0000, 16'hA5C3, 1'b0);
    run_one(1, 1'b0, 2'b11, 20'h00077, 16'h0000, 16'h1111, 1'b1);
    req0 = 1'b0;

    // Read with no byte lanes enabled
    tick();
    be0 = 2'b00; req0 = 1'b1;
    run_one(0, 1'b0, 2'b00, 20'h00040, 16'h0000, 16'h0000, 1'b1);

    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
